// File: rtl/estop_input_conditioner_if.sv
// Signal bundle for the E-STOP front-end conditioner.
// It carries the raw pins going in and the clean levels and pulses coming out.
interface estop_input_conditioner_if;
    logic estop_a_n;
    logic estop_b_n;
    logic ack_n;
    logic wdg_kick;
    logic estop_a;
    logic estop_b;
    logic estop_any;
    logic estop_fault;
    logic ack_pulse;
    logic kick_pulse;

    modport master (
        output estop_a_n, estop_b_n, ack_n, wdg_kick,
        input  estop_a, estop_b, estop_any, estop_fault, ack_pulse, kick_pulse
    );

    modport slave (
        input  estop_a_n, estop_b_n, ack_n, wdg_kick,
        output estop_a, estop_b, estop_any, estop_fault, ack_pulse, kick_pulse
    );
endinterface

// File: rtl/estop_input_conditioner.sv
// E-STOP front end: synchronisers, A/B/ACK debounce, ACK and kick pulses, A/B discrepancy fault.
// Defining ESTOP_DISCREPANCY_EN builds the discrepancy FSM; without it estop_fault is tied to 0.
//
// state       | meaning
// ST_AGREE    | debounced channels agree
// ST_MISMATCH | channels disagree, discrepancy timer running
// ST_FAULT    | discrepancy fault latched until both released and ACK pulses
module estop_input_conditioner #(
    parameter int DEBOUNCE_CYCLES    = 100,
    parameter int DISCREPANCY_CYCLES = 500,
    parameter int SYNC_STAGES        = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    estop_input_conditioner_if.slave   io
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    generate
        if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 || DISCREPANCY_CYCLES < 2) begin : g_param_check
            $error("estop_input_conditioner: SYNC_STAGES, DEBOUNCE_CYCLES and DISCREPANCY_CYCLES must be >= 2");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] sync_a;
    logic [SYNC_STAGES-1:0] sync_b;
    logic [SYNC_STAGES-1:0] sync_ack;
    logic [SYNC_STAGES-1:0] sync_kick;
    logic                   kick_prev;

    // Channel index 0 = E-STOP A, 1 = E-STOP B, 2 = ACK; all held in pressed = 1 polarity.
    logic [2:0]             sample;
    logic [2:0]             stable;
    logic [2:0]             stable_nxt;
    logic [DB_W-1:0]        db_cnt     [3];
    logic [DB_W-1:0]        db_cnt_nxt [3];

    logic                   ack_pulse_q;
    logic                   kick_pulse_q;
    logic                   any_q;
    logic                   fault_q;
    logic                   fault_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a    <= '1;
            sync_b    <= '1;
            sync_ack  <= '1;
            sync_kick <= '0;
            kick_prev <= 1'b0;
        end else begin
            sync_a    <= {sync_a[SYNC_STAGES-2:0],    io.estop_a_n};
            sync_b    <= {sync_b[SYNC_STAGES-2:0],    io.estop_b_n};
            sync_ack  <= {sync_ack[SYNC_STAGES-2:0],  io.ack_n};
            sync_kick <= {sync_kick[SYNC_STAGES-2:0], io.wdg_kick};
            kick_prev <= sync_kick[SYNC_STAGES-1];
        end
    end

    assign sample = {~sync_ack[SYNC_STAGES-1], ~sync_b[SYNC_STAGES-1], ~sync_a[SYNC_STAGES-1]};

    always_comb begin
        stable_nxt = stable;
        for (int i = 0; i < 3; i++) begin
            db_cnt_nxt[i] = '0;
            if (sample[i] != stable[i]) begin
                if (db_cnt[i] == DB_LAST) begin
                    stable_nxt[i] = sample[i];
                end else begin
                    db_cnt_nxt[i] = db_cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef ESTOP_DISCREPANCY_EN
    localparam int TM_W = $clog2(DISCREPANCY_CYCLES);
    localparam logic [TM_W-1:0] TM_LAST = TM_W'(DISCREPANCY_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_AGREE    = 2'd0,
        ST_MISMATCH = 2'd1,
        ST_FAULT    = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [TM_W-1:0] timer;
    logic [TM_W-1:0] timer_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_AGREE;
            timer <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    // The FSM works on the registered debounced levels and the registered ACK pulse.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        case (state)
            ST_AGREE: begin
                if (stable[0] != stable[1]) begin
                    state_nxt = ST_MISMATCH;
                    timer_nxt = '0;
                end
            end
            ST_MISMATCH: begin
                if (stable[0] == stable[1]) begin
                    state_nxt = ST_AGREE;
                end else if (timer == TM_LAST) begin
                    state_nxt = ST_FAULT;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            ST_FAULT: begin
                if (!stable[0] && !stable[1] && ack_pulse_q) begin
                    state_nxt = ST_AGREE;
                end
            end
            default: state_nxt = ST_AGREE;
        endcase
    end

    assign fault_nxt = (state_nxt == ST_FAULT);
`else
    assign fault_nxt = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            stable       <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
            ack_pulse_q  <= 1'b0;
            kick_pulse_q <= 1'b0;
            any_q        <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            stable       <= stable_nxt;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= db_cnt_nxt[i];
            end
            ack_pulse_q  <= stable_nxt[2] & ~stable[2];
            kick_pulse_q <= sync_kick[SYNC_STAGES-1] & ~kick_prev;
            any_q        <= stable_nxt[0] | stable_nxt[1] | fault_nxt;
            fault_q      <= fault_nxt;
        end
    end

    assign io.estop_a     = stable[0];
    assign io.estop_b     = stable[1];
    assign io.estop_any   = any_q;
    assign io.estop_fault = fault_q;
    assign io.ack_pulse   = ack_pulse_q;
    assign io.kick_pulse  = kick_pulse_q;

endmodule

// File: tb/tb_estop_input_conditioner.sv
// Bench for estop_input_conditioner: expected output levels are queued per cycle when
// stimulus is driven and compared on the falling edge of the matching cycle.
module tb_estop_input_conditioner;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    estop_input_conditioner_if bus ();

    estop_input_conditioner #(
        .DEBOUNCE_CYCLES    (100),
        .DISCREPANCY_CYCLES (500),
        .SYNC_STAGES        (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    localparam int SIG_A     = 0;
    localparam int SIG_B     = 1;
    localparam int SIG_ANY   = 2;
    localparam int SIG_FAULT = 3;
    localparam int SIG_ACK   = 4;
    localparam int SIG_KICK  = 5;

    typedef struct {
        int    cyc;
        int    sig;
        logic  val;
        string tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t keep_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, want);
        end
    endtask

    function automatic logic out_sig(input int s);
        case (s)
            SIG_A:     return bus.estop_a;
            SIG_B:     return bus.estop_b;
            SIG_ANY:   return bus.estop_any;
            SIG_FAULT: return bus.estop_fault;
            SIG_ACK:   return bus.ack_pulse;
            default:   return bus.kick_pulse;
        endcase
    endfunction

    function automatic string sig_name(input int s);
        case (s)
            SIG_A:     return "estop_a";
            SIG_B:     return "estop_b";
            SIG_ANY:   return "estop_any";
            SIG_FAULT: return "estop_fault";
            SIG_ACK:   return "ack_pulse";
            default:   return "kick_pulse";
        endcase
    endfunction

    always @(negedge clk) begin
        keep_q = {};
        foreach (exp_q[i]) begin
            if (exp_q[i].cyc == cyc) begin
                chk($sformatf("%s_%s@%0d", exp_q[i].tag, sig_name(exp_q[i].sig), cyc),
                    {31'd0, out_sig(exp_q[i].sig)}, {31'd0, exp_q[i].val});
            end else if (exp_q[i].cyc < cyc) begin
                chk($sformatf("%s_missed@%0d", exp_q[i].tag, exp_q[i].cyc), 32'd0, 32'd1);
            end else begin
                keep_q.push_back(exp_q[i]);
            end
        end
        exp_q = keep_q;
    end

    task automatic expect_range(input int sig, input int from, input int to, input logic val,
                                input string tag);
        for (int c = from; c <= to; c++) begin
            exp_q.push_back('{cyc: c, sig: sig, val: val, tag: tag});
        end
    endtask

    task automatic expect_all_zero(input int from, input int to, input string tag);
        for (int s = 0; s < 6; s++) expect_range(s, from, to, 1'b0, tag);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int c;
    int wait_cycles;

    initial begin
        rst           = 1'b1;
        bus.estop_a_n = 1'b1;
        bus.estop_b_n = 1'b1;
        bus.ack_n     = 1'b1;
        bus.wdg_kick  = 1'b0;
        step(3);

        // Reset state, then idle inputs for 200 cycles
        c = cyc;
        expect_all_zero(c, c + 200, "idle");
        rst = 1'b0;
        step(200);

        // Reset held with A pressed, released with A released: nothing may appear
        c = cyc;
        expect_all_zero(c + 1, c + 200, "rst_hold");
        rst = 1'b1;
        bus.estop_a_n = 1'b0;
        step(50);
        rst = 1'b0;
        bus.estop_a_n = 1'b1;
        step(150);

        // Short press of A is rejected
        c = cyc;
        expect_range(SIG_A,     c + 1, c + 200, 1'b0, "glitch60");
        expect_range(SIG_ANY,   c + 1, c + 200, 1'b0, "glitch60");
        bus.estop_a_n = 1'b0;
        step(60);
        bus.estop_a_n = 1'b1;
        step(140);

        // Long press of A: accepted exactly 102 edges after the fall, released 102 after the rise
        c = cyc;
        expect_range(SIG_A,     c + 1,   c + 101, 1'b0, "press150");
        expect_range(SIG_A,     c + 102, c + 251, 1'b1, "press150");
        expect_range(SIG_A,     c + 252, c + 260, 1'b0, "press150");
        expect_range(SIG_ANY,   c + 1,   c + 101, 1'b0, "press150");
        expect_range(SIG_ANY,   c + 102, c + 251, 1'b1, "press150");
        expect_range(SIG_ANY,   c + 252, c + 260, 1'b0, "press150");
        expect_range(SIG_FAULT, c + 1,   c + 260, 1'b0, "press150");
        bus.estop_a_n = 1'b0;
        step(150);
        bus.estop_a_n = 1'b1;
        step(120);

        // Reset in the middle of a debounce restarts the count from scratch
        c = cyc;
        expect_range(SIG_A, c + 1,   c + 184, 1'b0, "rst_mid");
        expect_range(SIG_A, c + 185, c + 190, 1'b1, "rst_mid");
        bus.estop_a_n = 1'b0;
        step(80);
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(110);
        bus.estop_a_n = 1'b1;
        step(120);

        // Three ACK presses: one pulse each on press, none on release
        for (int k = 0; k < 3; k++) begin
            c = cyc;
            expect_range(SIG_ACK, c + 1,   c + 101, 1'b0, $sformatf("ack%0d", k));
            expect_range(SIG_ACK, c + 102, c + 102, 1'b1, $sformatf("ack%0d", k));
            expect_range(SIG_ACK, c + 103, c + 249, 1'b0, $sformatf("ack%0d", k));
            bus.ack_n = 1'b0;
            step(120);
            bus.ack_n = 1'b1;
            step(130);
        end

        // Watchdog kick: one pulse at edge +3 for both a short and a long high level
        c = cyc;
        expect_range(SIG_KICK, c + 1, c + 2,  1'b0, "kick2");
        expect_range(SIG_KICK, c + 3, c + 3,  1'b1, "kick2");
        expect_range(SIG_KICK, c + 4, c + 30, 1'b0, "kick2");
        bus.wdg_kick = 1'b1;
        step(2);
        bus.wdg_kick = 1'b0;
        step(28);
        c = cyc;
        expect_range(SIG_KICK, c + 1, c + 2,  1'b0, "kick40");
        expect_range(SIG_KICK, c + 3, c + 3,  1'b1, "kick40");
        expect_range(SIG_KICK, c + 4, c + 60, 1'b0, "kick40");
        bus.wdg_kick = 1'b1;
        step(40);
        bus.wdg_kick = 1'b0;
        step(20);

`ifdef ESTOP_DISCREPANCY_EN
        // A alone: fault 501 edges after estop_a rises, ACK ignored while A held,
        // cleared by ACK once both channels are released
        c = cyc;
        expect_range(SIG_A,     c + 1,    c + 101,  1'b0, "fault");
        expect_range(SIG_A,     c + 102,  c + 1001, 1'b1, "fault");
        expect_range(SIG_A,     c + 1002, c + 1150, 1'b0, "fault");
        expect_range(SIG_FAULT, c + 1,    c + 602,  1'b0, "fault");
        expect_range(SIG_FAULT, c + 603,  c + 1112, 1'b1, "fault");
        expect_range(SIG_FAULT, c + 1113, c + 1150, 1'b0, "fault");
        expect_range(SIG_ANY,   c + 1,    c + 101,  1'b0, "fault");
        expect_range(SIG_ANY,   c + 102,  c + 1112, 1'b1, "fault");
        expect_range(SIG_ANY,   c + 1113, c + 1150, 1'b0, "fault");
        expect_range(SIG_ACK,   c + 1,    c + 801,  1'b0, "fault");
        expect_range(SIG_ACK,   c + 802,  c + 802,  1'b1, "fault");
        expect_range(SIG_ACK,   c + 803,  c + 1111, 1'b0, "fault");
        expect_range(SIG_ACK,   c + 1112, c + 1112, 1'b1, "fault");
        expect_range(SIG_ACK,   c + 1113, c + 1150, 1'b0, "fault");
        bus.estop_a_n = 1'b0;
        step(700);
        bus.ack_n = 1'b0;
        step(120);
        bus.ack_n = 1'b1;
        step(80);
        bus.estop_a_n = 1'b1;
        step(110);
        bus.ack_n = 1'b0;
        step(120);
        bus.ack_n = 1'b1;
        step(150);

        // B follows A within the discrepancy window: no fault
        c = cyc;
        expect_range(SIG_A,     c + 102, c + 700, 1'b1, "ab300");
        expect_range(SIG_B,     c + 1,   c + 401, 1'b0, "ab300");
        expect_range(SIG_B,     c + 402, c + 700, 1'b1, "ab300");
        expect_range(SIG_ANY,   c + 1,   c + 101, 1'b0, "ab300");
        expect_range(SIG_ANY,   c + 102, c + 700, 1'b1, "ab300");
        expect_range(SIG_FAULT, c + 1,   c + 700, 1'b0, "ab300");
        bus.estop_a_n = 1'b0;
        step(300);
        bus.estop_b_n = 1'b0;
        step(400);
        bus.estop_a_n = 1'b1;
        bus.estop_b_n = 1'b1;
        step(150);
`else
        // Without the discrepancy check a lone channel never faults
        c = cyc;
        expect_range(SIG_A,     c + 102, c + 2000, 1'b1, "nofault");
        expect_range(SIG_ANY,   c + 1,   c + 101,  1'b0, "nofault");
        expect_range(SIG_ANY,   c + 102, c + 2000, 1'b1, "nofault");
        expect_range(SIG_FAULT, c + 1,   c + 2000, 1'b0, "nofault");
        bus.estop_a_n = 1'b0;
        step(2000);
        bus.estop_a_n = 1'b1;
        step(150);
`endif

        wait_cycles = 0;
        while (exp_q.size() != 0 && wait_cycles < 300) begin
            step(1);
            wait_cycles++;
        end
        chk("drain", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
